// File: rtl/disp_mem_pkg.sv
// Shared constants and types for the display memory controller.
package disp_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_HOST,
    GNT_SCAN,
    GNT_CLR
  } gnt_e;

  // One buffered pixel: its address tag and its value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } pix_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry pixel FIFO between memory read data and the display driver.
module pix_fifo2
  import disp_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pix_t       push_pix,
  input  logic       pop,
  output pix_t       head,
  output logic [1:0] count
);

  pix_t       ent0_q, ent0_d;
  pix_t       ent1_q, ent1_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      if (wr_ptr_q) ent1_d = push_pix;
      else          ent0_d = push_pix;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  // NOTE: the storage entries are reset too, so pix_data/pix_addr come up as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = rd_ptr_q ? ent1_q : ent0_q;
  assign count = count_q;

endmodule

// File: rtl/disp_mem_ctrl.sv
// Arbitrates the single display-memory port between host, scanner and clear engine.
module disp_mem_ctrl
  import disp_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic              h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic              h_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              scan_en,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_sof,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_d_i,
  input  logic              mem_d_o
);

  state_e            state_q, state_d;
  gnt_e              last_gnt_q, last_gnt_d, gnt;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              inflight_q, inflight_d;
  logic              h_rvalid_q, h_rvalid_d;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic              pix_pop, scan_req;
  pix_t              head, push_pix;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    clr_cnt_d  = clr_cnt_q;
    scan_ptr_d = scan_ptr_q;
    tag_d      = tag_q;
    gnt        = GNT_NONE;
    mem_wr     = 1'b0;
    mem_d_i    = 1'b0;
    mem_addr   = mem_addr_q;

    // Occupancy counts the read in flight and credits a pixel leaving this cycle.
    pix_pop  = pix_valid && pix_ready;
    occ      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pix_pop};
    scan_req = scan_en && (occ < 3'd2);

    case (state_q)
      IDLE: begin
        if (h_req && scan_req) begin
          gnt        = (last_gnt_q == GNT_SCAN) ? GNT_HOST : GNT_SCAN;
          last_gnt_d = gnt;
        end else if (h_req) begin
          gnt = GNT_HOST;
        end else if (scan_req) begin
          gnt = GNT_SCAN;
        end
        if (clear_start) state_d = CLEAR;
      end
      CLEAR: begin
        gnt       = GNT_CLR;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (gnt)
      GNT_HOST: begin
        mem_addr = h_addr;
        mem_wr   = h_wr;
        mem_d_i  = h_wr && h_wdata;
      end
      GNT_SCAN: begin
        mem_addr   = scan_ptr_q;
        scan_ptr_d = scan_ptr_q + 1'b1;
        tag_d      = scan_ptr_q;
      end
      GNT_CLR: begin
        mem_addr = clr_cnt_q;
        mem_wr   = 1'b1;
      end
      default: ;
    endcase

    h_gnt      = (gnt == GNT_HOST);
    h_rvalid_d = h_gnt && !h_wr;
    inflight_d = (gnt == GNT_SCAN);
    mem_addr_d = mem_addr;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_SCAN;
      clr_cnt_q  <= '0;
      scan_ptr_q <= '0;
      tag_q      <= '0;
      mem_addr_q <= '0;
      inflight_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      clr_cnt_q  <= clr_cnt_d;
      scan_ptr_q <= scan_ptr_d;
      tag_q      <= tag_d;
      mem_addr_q <= mem_addr_d;
      inflight_q <= inflight_d;
      h_rvalid_q <= h_rvalid_d;
    end
  end

  assign push_pix = '{addr: tag_q, data: mem_d_o};

  pix_fifo2 u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_pix (push_pix),
    .pop      (pix_pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign h_rvalid   = h_rvalid_q;
  assign h_rdata    = h_rvalid_q && mem_d_o;
  assign clear_busy = (state_q == CLEAR);
  assign pix_valid  = (fifo_count != 2'd0);
  assign pix_data   = head.data;
  assign pix_addr   = head.addr;
  assign pix_sof    = pix_valid && (head.addr == '0);

endmodule

// File: tb/tb_disp_mem_ctrl.sv
// Scoreboard bench for disp_mem_ctrl with a behavioural 1x1024 synchronous memory.
module tb_disp_mem_ctrl;
  import disp_mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              h_req, h_wr, h_wdata, clear_start, scan_en, pix_ready;
  logic [ADDR_W-1:0] h_addr;
  logic              h_gnt, h_rvalid, h_rdata, clear_busy;
  logic              pix_valid, pix_data, pix_sof;
  logic [ADDR_W-1:0] pix_addr, mem_addr;
  logic              mem_wr, mem_d_i;
  logic              mem_d_o = 1'b0;

  disp_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .scan_en(scan_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_addr(pix_addr), .pix_sof(pix_sof),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_d_i(mem_d_i), .mem_d_o(mem_d_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model; bd_op 1 loads address parity, 2 loads all ones.
  logic       mem [DEPTH];
  logic [1:0] bd_op = 2'd0;
  always @(posedge clk) begin
    if (bd_op == 2'd1) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 1'((i & 1) != 0);
    end else if (bd_op == 2'd2) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_d_i;
    end
    mem_d_o <= mem[mem_addr];
  end

  typedef struct packed {
    logic data;
    int   cyc;
  } hexp_t;

  logic              exp_img [DEPTH];
  logic [ADDR_W-1:0] pix_q [$];
  hexp_t             hq [$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                pix_cnt = 0;
  int                sof_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic refill_pix();
    pix_q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) pix_q.push_back(ADDR_W'(i % DEPTH));
  endtask

  task automatic host_op(input logic wr, input int addr, input logic wd, output int waited);
    logic got;
    got    = 1'b0;
    waited = 0;
    h_req = 1'b1; h_wr = wr; h_addr = ADDR_W'(addr); h_wdata = wd;
    while (!got && waited < 3000) begin
      @(negedge clk);
      if (h_gnt) begin
        got = 1'b1;
        if (wr) begin
          check("host_wr_port", {mem_wr, mem_addr, mem_d_i}, {1'b1, ADDR_W'(addr), wd});
          exp_img[addr] = wd;
        end else begin
          check("host_rd_port", {mem_wr, mem_addr}, {1'b0, ADDR_W'(addr)});
          hq.push_back('{data: exp_img[addr], cyc: cyc + 1});
        end
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    h_req = 1'b0;
    if (!got) check("host_gnt_timeout", 32'(got), 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or read data.
  initial begin
    logic [ADDR_W-1:0] pa;
    hexp_t             he;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pix_valid && pix_ready) begin
          if (pix_q.size() == 0) begin
            check("pix_unexpected", 32'(pix_addr), 32'hFFFF);
          end else begin
            pa = pix_q.pop_front();
            check("pixel", {pix_addr, pix_sof, pix_data}, {pa, (pa == '0), exp_img[pa]});
            pix_cnt++;
            if (pix_sof) sof_cnt++;
          end
        end
        if (h_rvalid) begin
          if (hq.size() == 0) begin
            check("h_rvalid_spurious", 32'(h_rvalid), 0);
          end else begin
            he = hq.pop_front();
            check("h_rdata", 32'(h_rdata), 32'(he.data));
            check("h_rvalid_cycle", cyc, he.cyc);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, w, busy_cnt, gnt_in_clr, clr_bad, iter;
    logic [ADDR_W-1:0] a5;
    logic done;

    reset = 1'b1; h_req = 1'b0; h_wr = 1'b0; h_addr = '0; h_wdata = 1'b0;
    clear_start = 1'b0; scan_en = 1'b0; pix_ready = 1'b0;
    bd_op = 2'd1;
    for (int i = 0; i < DEPTH; i++) exp_img[i] = 1'((i & 1) != 0);
    refill_pix();
    tick(1);
    bd_op = 2'd0;
    tick(2);
    @(negedge clk);
    check("reset_flags", {h_gnt, h_rvalid, h_rdata, clear_busy, pix_valid, pix_data,
                          pix_sof, mem_wr, mem_d_i}, 0);
    check("reset_addrs", {pix_addr, mem_addr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full frame scan plus wrap, steady-state throughput.
    scan_en = 1'b1; pix_ready = 1'b1;
    tick(4);
    p0 = pix_cnt;
    tick(1024);
    check("scan_throughput", pix_cnt - p0, 1024);
    tick(70);
    check("sof_count", sof_cnt, 2);
    scan_en = 1'b0;
    tick(8);

    // Host writes and reads.
    host_op(1'b1, 5, 1'b0, w);
    check("host_gnt_immediate", w, 0);
    host_op(1'b0, 5, 1'b0, w);
    host_op(1'b1, 5, 1'b1, w);
    host_op(1'b0, 5, 1'b0, w);
    host_op(1'b1, 6, 1'b1, w);
    host_op(1'b0, 6, 1'b0, w);
    tick(3);

    // Contested arbitration alternates, host takes the first tie.
    scan_en = 1'b1; h_req = 1'b1; h_wr = 1'b0; h_addr = ADDR_W'(6);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_host_gnt", 32'(h_gnt), 32'((k % 2) == 0));
      if (h_gnt) hq.push_back('{data: exp_img[6], cyc: cyc + 1});
      @(posedge clk); #1;
    end
    h_req = 1'b0; scan_en = 1'b0;
    tick(6);

    // Back-pressure: at most two pixels buffered, no reads while full.
    pix_ready = 1'b0; scan_en = 1'b1;
    tick(5);
    a5 = mem_addr;
    tick(15);
    check("stall_no_read", 32'(mem_addr), 32'(a5));
    check("stall_valid", 32'(pix_valid), 1);
    scan_en = 1'b0; pix_ready = 1'b1;
    p0 = pix_cnt;
    tick(10);
    check("stall_drain_count", pix_cnt - p0, 2);

    // Clear of an all-ones array with a host request waiting.
    bd_op = 2'd2;
    tick(1);
    bd_op = 2'd0;
    for (int i = 0; i < DEPTH; i++) exp_img[i] = 1'b1;
    host_op(1'b0, 7, 1'b0, w);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    h_req = 1'b1; h_wr = 1'b0; h_addr = ADDR_W'(7);
    busy_cnt = 0; gnt_in_clr = 0; clr_bad = 0; done = 1'b0; iter = 0;
    while (!done && iter < 1200) begin
      @(negedge clk);
      iter++;
      if (clear_busy) begin
        if (h_gnt) gnt_in_clr++;
        if (!(mem_wr && !mem_d_i && mem_addr == ADDR_W'(busy_cnt))) clr_bad++;
        busy_cnt++;
      end else begin
        done = 1'b1;
        for (int i = 0; i < DEPTH; i++) exp_img[i] = 1'b0;
        check("gnt_after_clear", 32'(h_gnt), 1);
        if (h_gnt) hq.push_back('{data: 1'b0, cyc: cyc + 1});
      end
      @(posedge clk); #1;
    end
    h_req = 1'b0;
    check("clear_busy_cycles", busy_cnt, DEPTH);
    check("no_gnt_in_clear", gnt_in_clr, 0);
    check("clear_writes", clr_bad, 0);
    host_op(1'b0, 0, 1'b0, w);
    host_op(1'b0, 512, 1'b0, w);
    host_op(1'b0, 1023, 1'b0, w);
    scan_en = 1'b1;
    tick(40);
    scan_en = 1'b0;
    tick(6);

    // Reset in the middle of a clear.
    bd_op = 2'd2;
    tick(1);
    bd_op = 2'd0;
    for (int i = 0; i < DEPTH; i++) exp_img[i] = 1'b1;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    done = 1'b0; iter = 0;
    while (!done && iter < 400) begin
      @(negedge clk);
      iter++;
      if (clear_busy && mem_addr == ADDR_W'(300)) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reached_clear_300", 32'(done), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midclear_reset_flags", {h_gnt, h_rvalid, h_rdata, clear_busy, pix_valid, pix_data,
                                   pix_sof, mem_wr, mem_d_i}, 0);
    check("midclear_reset_addrs", {pix_addr, mem_addr}, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= 300; i++) exp_img[i] = 1'b0;
    refill_pix();
    host_op(1'b0, 0, 1'b0, w);
    check("idle_after_reset", w, 0);
    host_op(1'b0, 300, 1'b0, w);
    host_op(1'b0, 301, 1'b0, w);
    sof_cnt = 0;
    scan_en = 1'b1;
    tick(400);
    scan_en = 1'b0;
    tick(8);
    check("sof_after_reset", sof_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
